// File: rtl/vcache_dma_wormhole_initiator_if.sv
// vcache DMA port and wormhole link bundle for the DMA initiator.
// Link words are packed {v, data, ready_and_rev}.
interface vcache_dma_wormhole_initiator_if #(
  parameter int addr_width_p = 32,
  parameter int dma_width_p  = 64,
  parameter int link_width_p = 66
);
  logic                    dma_pkt_v_i;
  logic                    dma_pkt_write_not_read_i;
  logic [addr_width_p-1:0] dma_pkt_addr_i;
  logic                    dma_pkt_ready_o;
  logic [dma_width_p-1:0]  dma_data_i;
  logic                    dma_data_v_i;
  logic                    dma_data_yumi_o;
  logic [dma_width_p-1:0]  dma_data_o;
  logic                    dma_data_v_o;
  logic                    dma_data_ready_i;
  logic [link_width_p-1:0] wh_link_sif_i;
  logic [link_width_p-1:0] wh_link_sif_o;

  modport master (
    input  dma_pkt_v_i, dma_pkt_write_not_read_i,
    input  dma_pkt_addr_i, dma_data_i, dma_data_v_i,
    input  dma_data_ready_i, wh_link_sif_i,
    output dma_pkt_ready_o, dma_data_yumi_o,
    output dma_data_o, dma_data_v_o, wh_link_sif_o
  );

  modport slave (
    output dma_pkt_v_i, dma_pkt_write_not_read_i,
    output dma_pkt_addr_i, dma_data_i, dma_data_v_i,
    output dma_data_ready_i, wh_link_sif_i,
    input  dma_pkt_ready_o, dma_data_yumi_o,
    input  dma_data_o, dma_data_v_o, wh_link_sif_o
  );
endinterface

// File: rtl/vcache_dma_wormhole_initiator.sv
// vcache DMA initiator: requests become wormhole packets,
// fill responses are streamed back to the cache.
module vcache_dma_wormhole_initiator #(
  parameter int vcache_data_width_p          = 32,
  parameter int vcache_block_size_in_words_p = 8,
  parameter int vcache_dma_data_width_p      = 64,
  parameter int addr_width_p                 = 32,
  parameter int wh_flit_width_p              = 64,
  parameter int wh_cord_width_p              = 7,
  parameter int wh_len_width_p               = 4,
  parameter int wh_cid_width_p               = 2,
  parameter int max_out_reads_p              = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [wh_cord_width_p-1:0] my_cord_i,
  input  logic [wh_cord_width_p-1:0] dest_cord_i,
  input  logic [wh_cid_width_p-1:0]  my_cid_i,
  vcache_dma_wormhole_initiator_if.master bus
);
  localparam int data_len_lp = vcache_data_width_p
    * vcache_block_size_in_words_p / vcache_dma_data_width_p;
  localparam int cnt_w_lp =
    (data_len_lp > 1) ? $clog2(data_len_lp) : 1;
  localparam int rd_w_lp = $clog2(max_out_reads_p + 1);
  localparam int hdr_w_lp =
    2 * wh_cord_width_p + wh_len_width_p + wh_cid_width_p + 1;
  localparam logic [cnt_w_lp-1:0] last_lp =
    cnt_w_lp'(data_len_lp - 1);
  localparam logic [wh_len_width_p-1:0] wr_len_lp =
    wh_len_width_p'(1 + data_len_lp);
  localparam logic [wh_len_width_p-1:0] rd_len_lp =
    wh_len_width_p'(1);
  localparam logic [rd_w_lp-1:0] max_rd_lp =
    rd_w_lp'(max_out_reads_p);

  typedef enum logic [1:0] {
    TX_IDLE, TX_HDR, TX_ADDR, TX_DATA
  } tx_state_e;
  typedef enum logic {RX_HDR, RX_DATA} rx_state_e;

  tx_state_e                tx_state_r;
  rx_state_e                rx_state_r;
  logic                     live_r;
  logic                     wnr_r;
  logic [addr_width_p-1:0]  addr_r;
  logic [cnt_w_lp-1:0]      tx_cnt_r;
  logic [cnt_w_lp-1:0]      rx_cnt_r;
  logic [rd_w_lp-1:0]       out_reads_r;

  logic                       in_v;
  logic                       in_rdy;
  logic [wh_flit_width_p-1:0] in_data;
  logic                       out_v;
  logic                       out_rdy;
  logic [wh_flit_width_p-1:0] out_data;
  logic [wh_len_width_p-1:0]  len;
  logic [hdr_w_lp-1:0]        hdr;
  logic en, rx_data, pkt_fire, tx_fire, yumi;
  logic rx_fire, rd_inc, rd_dec;

  assign {in_v, in_data, in_rdy} = bus.wh_link_sif_i;

  // Outputs stay quiet while in reset and for one cycle after.
  assign en = live_r & reset_n_i;
  assign rx_data = (rx_state_r == RX_DATA);

  assign len = wnr_r ? wr_len_lp : rd_len_lp;
  assign hdr = {wnr_r, my_cord_i, my_cid_i, len, dest_cord_i};

  always_comb begin
    out_v    = 1'b0;
    out_data = '0;
    if (en) begin
      case (tx_state_r)
        TX_HDR: begin
          out_v    = 1'b1;
          out_data = wh_flit_width_p'(hdr);
        end
        TX_ADDR: begin
          out_v    = 1'b1;
          out_data = wh_flit_width_p'(addr_r);
        end
        TX_DATA: begin
          out_v    = bus.dma_data_v_i;
          out_data = bus.dma_data_i;
        end
        default: ;
      endcase
    end
  end

  assign out_rdy = en & (~rx_data | bus.dma_data_ready_i);
  assign bus.wh_link_sif_o = {out_v, out_data, out_rdy};

  assign bus.dma_pkt_ready_o = en & (tx_state_r == TX_IDLE)
    & (bus.dma_pkt_write_not_read_i | (out_reads_r != max_rd_lp));
  assign yumi = en & (tx_state_r == TX_DATA)
    & bus.dma_data_v_i & in_rdy;
  assign bus.dma_data_yumi_o = yumi;

  assign bus.dma_data_v_o = en & rx_data & in_v;
  assign bus.dma_data_o = {wh_flit_width_p{en & rx_data}} & in_data;

  assign pkt_fire = bus.dma_pkt_v_i & bus.dma_pkt_ready_o;
  assign tx_fire  = out_v & in_rdy;
  assign rx_fire  = in_v & out_rdy;
  assign rd_inc   = pkt_fire & ~bus.dma_pkt_write_not_read_i;
  assign rd_dec   = rx_fire & rx_data & (rx_cnt_r == last_lp);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      live_r      <= 1'b0;
      tx_state_r  <= TX_IDLE;
      rx_state_r  <= RX_HDR;
      wnr_r       <= 1'b0;
      addr_r      <= '0;
      tx_cnt_r    <= '0;
      rx_cnt_r    <= '0;
      out_reads_r <= '0;
    end else begin
      live_r <= 1'b1;
      case (tx_state_r)
        TX_IDLE: if (pkt_fire) begin
          wnr_r      <= bus.dma_pkt_write_not_read_i;
          addr_r     <= bus.dma_pkt_addr_i;
          tx_state_r <= TX_HDR;
        end
        TX_HDR: if (tx_fire) tx_state_r <= TX_ADDR;
        TX_ADDR: if (tx_fire)
          tx_state_r <= wnr_r ? TX_DATA : TX_IDLE;
        TX_DATA: if (yumi) begin
          if (tx_cnt_r == last_lp) begin
            tx_cnt_r   <= '0;
            tx_state_r <= TX_IDLE;
          end else begin
            tx_cnt_r <= tx_cnt_r + 1'b1;
          end
        end
        default: tx_state_r <= TX_IDLE;
      endcase
      case (rx_state_r)
        RX_HDR: if (rx_fire) rx_state_r <= RX_DATA;
        RX_DATA: if (rx_fire) begin
          if (rx_cnt_r == last_lp) begin
            rx_cnt_r   <= '0;
            rx_state_r <= RX_HDR;
          end else begin
            rx_cnt_r <= rx_cnt_r + 1'b1;
          end
        end
        default: rx_state_r <= RX_HDR;
      endcase
      out_reads_r <= out_reads_r + rd_w_lp'(rd_inc)
        - rd_w_lp'(rd_dec);
    end
  end

`ifndef SYNTHESIS
  // A fill with no read outstanding means the responder misbehaved.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && !rx_data && rx_fire)
      assert (out_reads_r != '0);
  end
`endif
endmodule

// File: tb/tb_vcache_dma_wormhole_initiator.sv
// Randomized bench for the vcache DMA wormhole initiator.
// Flits are predicted from header field arithmetic.
module tb_vcache_dma_wormhole_initiator;
  localparam int W   = 64;
  localparam int LW  = W + 2;
  localparam int LEN = 4;
  localparam int MAX = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [6:0] my_cord = 7'h12;
  logic [6:0] dest_cord = 7'h05;
  logic [1:0] my_cid = 2'd1;
  logic lin_v = 1'b0;
  logic lin_rdy = 1'b0;
  logic [W-1:0] lin_data = '0;
  int errors = 0;
  int checks = 0;
  int model_out = 0;
  logic [W-1:0] none[$];

  vcache_dma_wormhole_initiator_if #(
    .addr_width_p(32), .dma_width_p(W), .link_width_p(LW)
  ) bus ();

  assign bus.wh_link_sif_i = {lin_v, lin_data, lin_rdy};

  logic out_v, out_rdy;
  logic [W-1:0] out_d;
  assign out_v   = bus.wh_link_sif_o[LW-1];
  assign out_d   = bus.wh_link_sif_o[W:1];
  assign out_rdy = bus.wh_link_sif_o[0];

  vcache_dma_wormhole_initiator dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .my_cord_i(my_cord),
    .dest_cord_i(dest_cord),
    .my_cid_i(my_cid),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [W-1:0] exp_hdr(input bit wnr);
    logic [W-1:0] l;
    l = wnr ? 64'((1 + LEN) % 16) : 64'd1;
    return 64'(dest_cord) + (l << 7) + (64'(my_cid) << 11)
      + (64'(my_cord) << 13) + (64'(wnr) << 20);
  endfunction

  function automatic logic [W-1:0] outs_vec();
    return {bus.dma_pkt_ready_o, bus.dma_data_yumi_o,
      bus.dma_data_v_o, bus.dma_data_o[W-4:0]}
      | 64'(bus.wh_link_sif_o != '0);
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input bit wnr, input logic [31:0] a);
    bus.dma_pkt_v_i = 1'b1;
    bus.dma_pkt_write_not_read_i = wnr;
    bus.dma_pkt_addr_i = a;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.dma_pkt_ready_o === 1'b1) begin
        checks++;
        next();
        bus.dma_pkt_v_i = 1'b0;
        if (!wnr) model_out++;
        return;
      end
      next();
    end
    bus.dma_pkt_v_i = 1'b0;
    checks++;
    errors++;
    $display("FAIL req_accept got=timeout req=accept");
  endtask

  task automatic collect_tx(
    input int n, input int rdy_pct, input int dv_pct,
    input logic [W-1:0] beats_in[$],
    output logic [W-1:0] flits[$],
    output int lat, output int last,
    output int viol, output int yumis);
    logic [W-1:0] beats[$];
    logic [W-1:0] prev_d;
    bit held, prev_stall;
    int cyc;
    beats = beats_in;
    flits = {};
    lat = -1; last = -1; viol = 0; yumis = 0;
    held = 0; prev_stall = 0; prev_d = '0; cyc = 0;
    while (flits.size() < n && cyc < 500) begin
      lin_rdy = ($urandom_range(99) < rdy_pct);
      if (!held && beats.size() > 0
          && $urandom_range(99) < dv_pct) held = 1;
      bus.dma_data_v_i = held;
      bus.dma_data_i = held ? beats[0]
        : {$urandom, $urandom};
      @(negedge clk);
      if (prev_stall && (out_v !== 1'b1 || out_d !== prev_d))
        viol++;
      prev_stall = (out_v === 1'b1) && !lin_rdy;
      prev_d = out_d;
      if (out_v === 1'b1 && lin_rdy) begin
        if (lat < 0) lat = cyc;
        last = cyc;
        flits.push_back(out_d);
      end
      if (bus.dma_data_yumi_o === 1'b1) begin
        yumis++;
        if (!(out_v === 1'b1 && lin_rdy)) viol++;
        held = 0;
        if (beats.size() > 0) void'(beats.pop_front());
      end
      next();
      cyc++;
    end
    bus.dma_data_v_i = 1'b0;
    lin_rdy = 1'b0;
  endtask

  task automatic inject_fill(
    input logic [W-1:0] beats[$],
    input int stall_at, input int stall_len,
    output logic [W-1:0] got[$],
    output int err, output logic rdy_last);
    logic [W-1:0] items[$];
    int idx, dcyc, cyc;
    items = beats;
    items.push_front({$urandom, $urandom});
    got = {}; err = 0; rdy_last = 1'bx;
    idx = 0; dcyc = 0; cyc = 0;
    while (idx < items.size() && cyc < 200) begin
      lin_v = 1'b1;
      lin_data = items[idx];
      bus.dma_data_ready_i = !(idx > 0 && dcyc >= stall_at
        && dcyc < stall_at + stall_len);
      @(negedge clk);
      if (idx == 0) begin
        if (bus.dma_data_v_o !== 1'b0) err++;
      end else begin
        if (out_rdy !== bus.dma_data_ready_i) err++;
        if (bus.dma_data_v_o !== 1'b1) err++;
        if (bus.dma_data_v_o === 1'b1 && bus.dma_data_ready_i)
          got.push_back(bus.dma_data_o);
        dcyc++;
      end
      if (out_rdy === 1'b1) begin
        idx++;
        if (idx == items.size()) begin
          rdy_last = bus.dma_pkt_ready_o;
          model_out--;
        end
      end
      next();
      cyc++;
    end
    if (idx < items.size()) err++;
    lin_v = 1'b0;
    bus.dma_data_ready_i = 1'b1;
  endtask

  task automatic check_fill(input string nm,
    input logic [W-1:0] exp[$], input logic [W-1:0] got[$],
    input int err);
    checks++;
    if (err !== 0) begin
      errors++;
      $display("FAIL %s_proto got=%0d req=0", nm, err);
    end
    for (int i = 0; i < exp.size(); i++) begin
      logic [W-1:0] g;
      g = (i < got.size()) ? got[i] : 'x;
      checks++;
      if (g !== exp[i]) begin
        errors++;
        $display("FAIL %s_beat%0d got=%h req=%h", nm, i, g, exp[i]);
      end
    end
  endtask

  task automatic check_flits(input string nm,
    input logic [W-1:0] exp[$], input logic [W-1:0] got[$]);
    checks++;
    if (got.size() !== exp.size()) begin
      errors++;
      $display("FAIL %s_count got=%0d req=%0d",
        nm, got.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      logic [W-1:0] g;
      g = (i < got.size()) ? got[i] : 'x;
      checks++;
      if (g !== exp[i]) begin
        errors++;
        $display("FAIL %s_flit%0d got=%h req=%h", nm, i, g, exp[i]);
      end
    end
  endtask

  function automatic void rand_beats(output logic [W-1:0] q[$]);
    q = {};
    for (int i = 0; i < LEN; i++) q.push_back({$urandom, $urandom});
  endfunction

  task automatic test_reset();
    bus.dma_pkt_v_i = 1'b1;
    bus.dma_pkt_write_not_read_i = 1'b1;
    bus.dma_pkt_addr_i = 32'h40;
    bus.dma_data_v_i = 1'b1;
    bus.dma_data_i = '1;
    bus.dma_data_ready_i = 1'b1;
    lin_rdy = 1'b1;
    reset_n = 1'b0;
    repeat (2) next();
    @(negedge clk);
    checks++;
    if (outs_vec() !== '0) begin
      errors++;
      $display("FAIL reset_hold got=%h req=0", outs_vec());
    end
    next();
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (outs_vec() !== '0) begin
      errors++;
      $display("FAIL reset_first got=%h req=0", outs_vec());
    end
    next();
    bus.dma_pkt_v_i = 1'b0;
    bus.dma_data_v_i = 1'b0;
    lin_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dma_pkt_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_pkt_ready got=%b req=1",
        bus.dma_pkt_ready_o);
    end
    checks++;
    if (out_rdy !== 1'b1 || out_v !== 1'b0) begin
      errors++;
      $display("FAIL reset_link got=%b%b req=10", out_rdy, out_v);
    end
    next();
  endtask

  task automatic test_read();
    logic [W-1:0] fl[$], exp[$], got[$], bt[$];
    int lat, last, viol, yu, err;
    logic rl;
    dest_cord = 7'h05; my_cord = 7'h12; my_cid = 2'd1;
    send_req(1'b0, 32'h0000_1040);
    collect_tx(2, 100, 0, none, fl, lat, last, viol, yu);
    exp = {exp_hdr(1'b0), 64'h1040};
    check_flits("read", exp, fl);
    checks++;
    if (lat !== 0 || last !== 1) begin
      errors++;
      $display("FAIL read_latency got=%0d/%0d req=0/1", lat, last);
    end
    bt = {64'hA0, 64'hA1, 64'hA2, 64'hA3};
    inject_fill(bt, 99, 0, got, err, rl);
    check_fill("read_fill", bt, got, err);
  endtask

  task automatic test_evict();
    logic [W-1:0] fl[$], exp[$], bt[$];
    int lat, last, viol, yu;
    bt = {64'hB0, 64'hB1, 64'hB2, 64'hB3};
    send_req(1'b1, 32'h0000_2000);
    collect_tx(6, 100, 100, bt, fl, lat, last, viol, yu);
    exp = {exp_hdr(1'b1), 64'h2000};
    foreach (bt[i]) exp.push_back(bt[i]);
    check_flits("evict", exp, fl);
    checks++;
    if (yu !== LEN || last !== 5 || viol !== 0) begin
      errors++;
      $display("FAIL evict_yumi got=%0d/%0d/%0d req=4/5/0",
        yu, last, viol);
    end
  endtask

  task automatic test_evict_stall();
    logic [W-1:0] fl[$], exp[$], bt[$];
    logic [31:0] a;
    int lat, last, viol, yu;
    for (int it = 0; it < 3; it++) begin
      dest_cord = 7'($urandom);
      my_cord = 7'($urandom);
      my_cid = 2'($urandom);
      a = $urandom & 32'hFFFF_FFC0;
      rand_beats(bt);
      send_req(1'b1, a);
      collect_tx(6, 50, 70, bt, fl, lat, last, viol, yu);
      exp = {exp_hdr(1'b1), 64'(a)};
      foreach (bt[i]) exp.push_back(bt[i]);
      check_flits("stall", exp, fl);
      checks++;
      if (viol !== 0 || yu !== LEN) begin
        errors++;
        $display("FAIL stall_hold got=%0d/%0d req=0/4", viol, yu);
      end
    end
  endtask

  task automatic test_max_reads();
    logic [W-1:0] fl[$], got[$], b1[$], b2[$];
    int lat, last, viol, yu, err;
    logic rl;
    for (int r = 0; r < MAX; r++) begin
      send_req(1'b0, $urandom & 32'hFFFF_FFC0);
      collect_tx(2, 100, 0, none, fl, lat, last, viol, yu);
    end
    bus.dma_pkt_write_not_read_i = 1'b0;
    bus.dma_pkt_v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.dma_pkt_ready_o !== (model_out < MAX)) begin
        errors++;
        $display("FAIL max_block got=%b req=%b",
          bus.dma_pkt_ready_o, model_out < MAX);
      end
      next();
    end
    bus.dma_pkt_v_i = 1'b0;
    bus.dma_pkt_write_not_read_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.dma_pkt_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL max_evict_ok got=%b req=1", bus.dma_pkt_ready_o);
    end
    next();
    bus.dma_pkt_write_not_read_i = 1'b0;
    rand_beats(b1);
    inject_fill(b1, 99, 0, got, err, rl);
    check_fill("max_fill1", b1, got, err);
    checks++;
    if (rl !== 1'b0) begin
      errors++;
      $display("FAIL max_last_beat got=%b req=0", rl);
    end
    @(negedge clk);
    checks++;
    if (bus.dma_pkt_ready_o !== (model_out < MAX)) begin
      errors++;
      $display("FAIL max_release got=%b req=%b",
        bus.dma_pkt_ready_o, model_out < MAX);
    end
    next();
    rand_beats(b2);
    inject_fill(b2, 1, 2, got, err, rl);
    check_fill("max_fill2", b2, got, err);
  endtask

  task automatic test_mid_fill();
    logic [W-1:0] fl[$], got[$], ba[$], bb[$], exp[$];
    int lat, last, viol, yu, err;
    logic rl;
    bit mid;
    logic [31:0] ab;
    send_req(1'b0, $urandom & 32'hFFFF_FFC0);
    collect_tx(2, 100, 0, none, fl, lat, last, viol, yu);
    rand_beats(ba);
    ab = $urandom & 32'hFFFF_FFC0;
    mid = 0;
    fork
      inject_fill(ba, 1, 3, got, err, rl);
      begin
        next();
        next();
        send_req(1'b0, ab);
        mid = (lin_v === 1'b1);
        collect_tx(2, 100, 0, none, fl, lat, last, viol, yu);
      end
    join
    check_fill("mid_fill", ba, got, err);
    checks++;
    if (mid !== 1'b1) begin
      errors++;
      $display("FAIL mid_accept got=%b req=1", mid);
    end
    exp = {exp_hdr(1'b0), 64'(ab)};
    check_flits("mid_read", exp, fl);
    rand_beats(bb);
    inject_fill(bb, 0, 1, got, err, rl);
    check_fill("mid_fill2", bb, got, err);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] fl[$], got[$], bt[$], exp[$];
    int lat, last, viol, yu, err;
    logic rl;
    logic [31:0] a;
    rand_beats(bt);
    send_req(1'b1, 32'h0000_3000);
    collect_tx(4, 100, 100, bt, fl, lat, last, viol, yu);
    bus.dma_data_v_i = 1'b1;
    bus.dma_data_i = bt[2];
    lin_rdy = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (outs_vec() !== '0) begin
      errors++;
      $display("FAIL rstmid_hold got=%h req=0", outs_vec());
    end
    next();
    reset_n = 1'b1;
    model_out = 0;
    @(negedge clk);
    checks++;
    if (outs_vec() !== '0) begin
      errors++;
      $display("FAIL rstmid_after got=%h req=0", outs_vec());
    end
    next();
    bus.dma_data_v_i = 1'b0;
    lin_rdy = 1'b0;
    a = $urandom & 32'hFFFF_FFC0;
    send_req(1'b0, a);
    collect_tx(2, 100, 0, none, fl, lat, last, viol, yu);
    exp = {exp_hdr(1'b0), 64'(a)};
    check_flits("rstmid_read", exp, fl);
    rand_beats(bt);
    inject_fill(bt, 99, 0, got, err, rl);
    check_fill("rstmid_fill", bt, got, err);
    rand_beats(bt);
    send_req(1'b1, a);
    collect_tx(6, 100, 100, bt, fl, lat, last, viol, yu);
    exp = {exp_hdr(1'b1), 64'(a)};
    foreach (bt[i]) exp.push_back(bt[i]);
    check_flits("rstmid_evict", exp, fl);
  endtask

  initial begin
    bus.dma_pkt_v_i = 1'b0;
    bus.dma_pkt_write_not_read_i = 1'b0;
    bus.dma_pkt_addr_i = '0;
    bus.dma_data_v_i = 1'b0;
    bus.dma_data_i = '0;
    bus.dma_data_ready_i = 1'b1;
    test_reset();
    test_read();
    test_evict();
    test_evict_stall();
    test_max_reads();
    test_mid_fill();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
